// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared constants and types for the LEGv8 multi-cycle control unit:
//   opcode patterns, ALU function-select codes, FSM state encodings,
//   control-word layout, B.cond condition codes and the condition evaluator.
//   No ports.
package control_unit_pkg;

    // Opcode patterns, grouped by how many leading instruction bits they use
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_EORI = 10'b1101001000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    // fs: [0] invert B, [1] invert A, [4:2] operation
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;   // used together with c0=1
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_BR    = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU_R, CLS_SHIFT, CLS_ALU_I, CLS_LDUR,
        CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_B, CLS_BCOND
    } instr_class_e;

    // Field order gives bit offsets: c0 at [0] ... reg_addr at [29:25]
    typedef struct packed {
        logic [4:0] reg_addr;
        logic [4:0] a_addr;
        logic [4:0] b_addr;
        logic [4:0] fs;
        logic       reg_w;
        logic       b_sel;
        logic       b_en;
        logic       alu_en;
        logic       mem_en;
        logic       chip_sel;
        logic       mem_w;
        logic       mem_r;
        logic       stat_en;
        logic       c0;
    } cw_t;

    // Returns {supported, taken} for a B.cond condition code
    function automatic logic [1:0] eval_cond(input logic [3:0] cond, input logic v,
                                             input logic n, input logic z);
        logic [1:0] res;
        res = 2'b10;
        case (cond)
            COND_EQ: res[0] = z;
            COND_NE: res[0] = ~z;
            COND_GE: res[0] = (n == v);
            COND_LT: res[0] = (n != v);
            COND_GT: res[0] = ~z & (n == v);
            COND_LE: res[0] = z | (n != v);
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// instr_decoder
//   Combinational decode of the instruction register into an instruction
//   class, ALU function select, and the extended immediate for that class.
//   Branch offsets are returned already shifted by 2 and reduced by 4, since
//   the PC has been incremented by the time the offset is applied.
//   Optional feature macro: BCOND_EN (decode B.cond; otherwise it is illegal).
// Ports
//   i_ir       in  32      instruction register
//   o_class    out enum    instruction class
//   o_rd       out 5       Rd / Rt / cond field [4:0]
//   o_rn       out 5       Rn field
//   o_rm       out 5       Rm field
//   o_fs       out 5       ALU function select
//   o_c0       out 1       ALU carry-in
//   o_stat_en  out 1       flag update enable
//   o_imm      out DATA_W  extended immediate / branch offset
module instr_decoder
    import control_unit_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       i_ir,
    output instr_class_e      o_class,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rn,
    output logic [4:0]        o_rm,
    output logic [4:0]        o_fs,
    output logic              o_c0,
    output logic              o_stat_en,
    output logic [DATA_W-1:0] o_imm
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    logic [10:0]       w_op11;
    logic [9:0]        w_op10;
    logic [7:0]        w_op8;
    logic [5:0]        w_op6;
    logic [DATA_W-1:0] w_imm12;
    logic [DATA_W-1:0] w_shamt;
    logic [DATA_W-1:0] w_imm9;
    logic [DATA_W-1:0] w_br19;
    logic [DATA_W-1:0] w_br26;

    assign w_op11 = i_ir[31:21];
    assign w_op10 = i_ir[31:22];
    assign w_op8  = i_ir[31:24];
    assign w_op6  = i_ir[31:26];
    assign o_rd   = i_ir[4:0];
    assign o_rn   = i_ir[9:5];
    assign o_rm   = i_ir[20:16];

    assign w_imm12 = {{(DATA_W-12){1'b0}}, i_ir[21:10]};
    assign w_shamt = {{(DATA_W-6){1'b0}}, i_ir[15:10]};
    assign w_imm9  = {{(DATA_W-9){i_ir[20]}}, i_ir[20:12]};
    assign w_br19  = {{(DATA_W-21){i_ir[23]}}, i_ir[23:5], 2'b00} - PC_STEP;
    assign w_br26  = {{(DATA_W-28){i_ir[25]}}, i_ir[25:0], 2'b00} - PC_STEP;

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_fs      = FS_ADD;
        o_c0      = 1'b0;
        o_stat_en = 1'b0;
        o_imm     = '0;
        if (w_op11 == OP_ADD) begin
            o_class = CLS_ALU_R;
        end else if (w_op11 == OP_ADDS) begin
            o_class = CLS_ALU_R; o_stat_en = 1'b1;
        end else if (w_op11 == OP_SUB) begin
            o_class = CLS_ALU_R; o_fs = FS_SUB; o_c0 = 1'b1;
        end else if (w_op11 == OP_SUBS) begin
            o_class = CLS_ALU_R; o_fs = FS_SUB; o_c0 = 1'b1; o_stat_en = 1'b1;
        end else if (w_op11 == OP_AND) begin
            o_class = CLS_ALU_R; o_fs = FS_AND;
        end else if (w_op11 == OP_ORR) begin
            o_class = CLS_ALU_R; o_fs = FS_ORR;
        end else if (w_op11 == OP_EOR) begin
            o_class = CLS_ALU_R; o_fs = FS_EOR;
        end else if (w_op11 == OP_LSL) begin
            o_class = CLS_SHIFT; o_fs = FS_LSL; o_imm = w_shamt;
        end else if (w_op11 == OP_LSR) begin
            o_class = CLS_SHIFT; o_fs = FS_LSR; o_imm = w_shamt;
        end else if (w_op11 == OP_LDUR) begin
            o_class = CLS_LDUR; o_imm = w_imm9;
        end else if (w_op11 == OP_STUR) begin
            o_class = CLS_STUR; o_imm = w_imm9;
        end else if (w_op10 == OP_ADDI) begin
            o_class = CLS_ALU_I; o_imm = w_imm12;
        end else if (w_op10 == OP_SUBI) begin
            o_class = CLS_ALU_I; o_fs = FS_SUB; o_c0 = 1'b1; o_imm = w_imm12;
        end else if (w_op10 == OP_ANDI) begin
            o_class = CLS_ALU_I; o_fs = FS_AND; o_imm = w_imm12;
        end else if (w_op10 == OP_ORRI) begin
            o_class = CLS_ALU_I; o_fs = FS_ORR; o_imm = w_imm12;
        end else if (w_op10 == OP_EORI) begin
            o_class = CLS_ALU_I; o_fs = FS_EOR; o_imm = w_imm12;
        end else if (w_op8 == OP_CBZ) begin
            o_class = CLS_CBZ; o_imm = w_br19;
        end else if (w_op8 == OP_CBNZ) begin
            o_class = CLS_CBNZ; o_imm = w_br19;
        end else if (w_op8 == OP_BCOND) begin
`ifdef BCOND_EN
            o_class = CLS_BCOND; o_imm = w_br19;
`else
            o_class = CLS_ILLEGAL;
`endif
        end else if (w_op6 == OP_B) begin
            o_class = CLS_B; o_imm = w_br26;
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle LEGv8 control FSM (FETCH, EXEC, MEM, BR, HALT). Accepts an
//   instruction over a valid/ready handshake, latches it into the IR, and
//   drives the datapath control word, K constant and PC control from
//   state + IR. Branch decisions are registered at the end of EXEC.
//   Optional feature macro: BCOND_EN (B.cond support).
// Ports
//   clk          in  1       clock, rising edge
//   rst          in  1       asynchronous reset, active-high
//   instr        in  32      instruction word
//   instr_valid  in  1       instr valid
//   instr_ready  out 1       FSM in FETCH and ready to accept
//   status       in  5       {V,C,N,Z} flags [4:1], live zero [0]
//   k            out DATA_W  immediate / offset constant
//   cw           out 30      datapath control word (cw_t layout)
//   pc_en        out 1       PC load strobe
//   pc_sel       out 2       00 PC+4, 01 PC+k
//   halt         out 1       sticky illegal-opcode indicator
module control_unit
    import control_unit_pkg::*;
#(
    parameter int         DATA_W  = 64,
    parameter logic [4:0] ZR_ADDR = 5'd31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        status,
    output logic [DATA_W-1:0] k,
    output logic [29:0]       cw,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              halt
);

    logic [2:0]        r_state;
    logic [31:0]       r_ir;
    logic              r_taken;

    instr_class_e      w_class;
    logic [4:0]        w_rd;
    logic [4:0]        w_rn;
    logic [4:0]        w_rm;
    logic [4:0]        w_fs;
    logic              w_c0;
    logic              w_stat_en;
    logic [DATA_W-1:0] w_imm;
    logic [1:0]        w_cond;
    logic              w_unused_c;
    cw_t               w_cw;
    logic [DATA_W-1:0] w_k;
    logic              w_pc_en;
    logic [1:0]        w_pc_sel;

    instr_decoder #(.DATA_W(DATA_W)) u_dec (
        .i_ir      (r_ir),
        .o_class   (w_class),
        .o_rd      (w_rd),
        .o_rn      (w_rn),
        .o_rm      (w_rm),
        .o_fs      (w_fs),
        .o_c0      (w_c0),
        .o_stat_en (w_stat_en),
        .o_imm     (w_imm)
    );

    // Carry flag is not consulted by any supported condition
    assign w_unused_c = status[3];
    assign w_cond     = eval_cond(w_rd[3:0], status[4], status[2], status[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
            r_taken <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_class)
                        CLS_LDUR: r_state <= ST_MEM;
                        CLS_CBZ: begin
                            r_taken <= status[0];
                            r_state <= ST_BR;
                        end
                        CLS_CBNZ: begin
                            r_taken <= ~status[0];
                            r_state <= ST_BR;
                        end
                        CLS_BCOND: begin
                            if (w_cond[1]) begin
                                r_taken <= w_cond[0];
                                r_state <= ST_BR;
                            end else begin
                                r_state <= ST_HALT;
                            end
                        end
                        CLS_ILLEGAL: r_state <= ST_HALT;
                        default:     r_state <= ST_FETCH;
                    endcase
                end
                ST_MEM:  r_state <= ST_FETCH;
                ST_BR:   r_state <= ST_FETCH;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        w_cw     = '0;
        w_cw.fs  = FS_ADD;
        w_k      = '0;
        w_pc_en  = 1'b0;
        w_pc_sel = PC_SEL_INC;
        case (r_state)
            // PC+4 is loaded in the same cycle the instruction is accepted
            ST_FETCH: w_pc_en = instr_valid & ~rst;
            ST_EXEC: begin
                case (w_class)
                    CLS_ALU_R: begin
                        w_cw.reg_addr = w_rd;
                        w_cw.a_addr   = w_rn;
                        w_cw.b_addr   = w_rm;
                        w_cw.fs       = w_fs;
                        w_cw.c0       = w_c0;
                        w_cw.stat_en  = w_stat_en;
                        w_cw.reg_w    = 1'b1;
                        w_cw.alu_en   = 1'b1;
                    end
                    CLS_SHIFT, CLS_ALU_I: begin
                        w_cw.reg_addr = w_rd;
                        w_cw.a_addr   = w_rn;
                        w_cw.fs       = w_fs;
                        w_cw.c0       = w_c0;
                        w_cw.b_sel    = 1'b1;
                        w_cw.reg_w    = 1'b1;
                        w_cw.alu_en   = 1'b1;
                        w_k           = w_imm;
                    end
                    CLS_LDUR: begin
                        w_cw.a_addr   = w_rn;
                        w_cw.b_sel    = 1'b1;
                        w_cw.alu_en   = 1'b1;
                        w_cw.chip_sel = 1'b1;
                        w_cw.mem_r    = 1'b1;
                        w_k           = w_imm;
                    end
                    CLS_STUR: begin
                        w_cw.a_addr   = w_rn;
                        w_cw.b_addr   = w_rd;   // Rt supplies the store data
                        w_cw.b_en     = 1'b1;
                        w_cw.b_sel    = 1'b1;
                        w_cw.alu_en   = 1'b1;
                        w_cw.chip_sel = 1'b1;
                        w_cw.mem_w    = 1'b1;
                        w_k           = w_imm;
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        // Rt + XZR through the ALU produces the live zero flag
                        w_cw.a_addr   = w_rd;
                        w_cw.b_addr   = ZR_ADDR;
                        w_cw.alu_en   = 1'b1;
                    end
                    CLS_B: begin
                        w_pc_en  = 1'b1;
                        w_pc_sel = PC_SEL_BR;
                        w_k      = w_imm;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Address path held stable while the load data is written back
                w_cw.reg_addr = w_rd;
                w_cw.a_addr   = w_rn;
                w_cw.b_sel    = 1'b1;
                w_cw.alu_en   = 1'b1;
                w_cw.chip_sel = 1'b1;
                w_cw.mem_r    = 1'b1;
                w_cw.mem_en   = 1'b1;
                w_cw.reg_w    = 1'b1;
                w_k           = w_imm;
            end
            ST_BR: begin
                w_k = w_imm;
                if (r_taken) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = PC_SEL_BR;
                end
            end
            default: ;
        endcase
    end

    assign cw          = w_cw;
    assign k           = w_k;
    assign pc_en       = w_pc_en;
    assign pc_sel      = w_pc_sel;
    assign instr_ready = (r_state == ST_FETCH) & ~rst;
    assign halt        = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  status;
    logic [63:0] k;
    logic [29:0] cw;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        halt;

    control_unit #(.DATA_W(64), .ZR_ADDR(5'd31)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .status      (status),
        .k           (k),
        .cw          (cw),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [29:0] CW_IDLE = 30'h0000_2000;   // only fs = 01000

    typedef struct {
        string       name;
        logic [29:0] cw;
        logic [63:0] k;
        logic [4:0]  ctl;   // {pc_en, pc_sel, instr_ready, halt}
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [29:0] mkcw(input logic [4:0] ra, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] fs,
                                         input logic [9:0] bits);
        return {ra, a, b, fs, bits};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push(input string nm, input logic [29:0] c, input logic [63:0] kk,
                        input logic pe, input logic [1:0] ps, input logic rdy, input logic h);
        exp_t e;
        e.name = nm; e.cw = c; e.k = kk; e.ctl = {pe, ps, rdy, h};
        exp_q.push_back(e);
    endtask

    task automatic push_acc(input string nm);
        push({nm, ".acc"}, CW_IDLE, 64'd0, 1'b1, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic push_ex(input string nm, input logic [29:0] c, input logic [63:0] kk);
        push(nm, c, kk, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Present one instruction; n = number of cycles spent outside FETCH
    task automatic run(input logic [31:0] ins, input logic [4:0] st, input int n);
        @(posedge clk); #1;
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; status = st;
        repeat (n) @(posedge clk);
    endtask

    task automatic reset_checks(input string nm);
        @(negedge clk);
        chk({nm, ".ready"}, {63'd0, instr_ready}, 64'd0);
        chk({nm, ".pc_en"}, {63'd0, pc_en}, 64'd0);
        chk({nm, ".halt"},  {63'd0, halt}, 64'd0);
        chk({nm, ".cw"},    {34'd0, cw}, {34'd0, CW_IDLE});
        chk({nm, ".k"},     k, 64'd0);
    endtask

    // Monitor: every cycle the DUT is out of FETCH or strobing the PC is one output
    always @(negedge clk) begin
        if (!rst && (!instr_ready || pc_en)) begin
            if (exp_q.size() == 0) begin
                n_checks = n_checks + 1;
                $display("FAIL unexpected_output: got cw=%h k=%h ctl=%b expected no output",
                         cw, k, {pc_en, pc_sel, instr_ready, halt});
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn %-12s cw=%h k=%h pc_en=%b pc_sel=%b ready=%b halt=%b",
                         mon_e.name, cw, k, pc_en, pc_sel, instr_ready, halt);
                chk({mon_e.name, ".cw"},  {34'd0, cw}, {34'd0, mon_e.cw});
                chk({mon_e.name, ".k"},   k, mon_e.k);
                chk({mon_e.name, ".ctl"}, {59'd0, pc_en, pc_sel, instr_ready, halt},
                    {59'd0, mon_e.ctl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b1; status = 5'd0;
        instr = 32'h91000BE0;                       // ADDI X0, XZR, #2
        repeat (3) @(posedge clk);
        reset_checks("reset");

        push_acc("addi");
        push_ex("addi", mkcw(5'd0, 5'd31, 5'd0, 5'b01000, 10'b1101000000), 64'd2);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk);

        push_acc("sub");
        push_ex("sub", mkcw(5'd5, 5'd0, 5'd1, 5'b01001, 10'b1001000001), 64'd0);
        run(32'hCB010005, 5'd0, 1);

        push_acc("subs");
        push_ex("subs", mkcw(5'd5, 5'd0, 5'd1, 5'b01001, 10'b1001000011), 64'd0);
        run(32'hEB010005, 5'd0, 1);

        push_acc("eor");
        push_ex("eor", mkcw(5'd4, 5'd2, 5'd3, 5'b01100, 10'b1001000000), 64'd0);
        run(32'hCA030044, 5'd0, 1);

        push_acc("orri");
        push_ex("orri", mkcw(5'd9, 5'd1, 5'd0, 5'b00100, 10'b1101000000), 64'h0FFF);
        run(32'hB23FFC29, 5'd0, 1);

        push_acc("lsl");
        push_ex("lsl", mkcw(5'd6, 5'd2, 5'd0, 5'b10000, 10'b1101000000), 64'd3);
        run(32'hD3600C46, 5'd0, 1);

        push_acc("ldur");
        push_ex("ldur.ex", mkcw(5'd0, 5'd1, 5'd0, 5'b01000, 10'b0101010100), 64'hFFFF_FFFF_FFFF_FFF8);
        push_ex("ldur.mem", mkcw(5'd2, 5'd1, 5'd0, 5'b01000, 10'b1101110100), 64'hFFFF_FFFF_FFFF_FFF8);
        run(32'hF85F8022, 5'd0, 2);

        push_acc("stur");
        push_ex("stur", mkcw(5'd0, 5'd1, 5'd3, 5'b01000, 10'b0111011000), 64'd16);
        run(32'hF8010023, 5'd0, 1);

        push_acc("cbz_t");
        push_ex("cbz_t.ex", mkcw(5'd0, 5'd3, 5'd31, 5'b01000, 10'b0001000000), 64'd0);
        push("cbz_t.br", CW_IDLE, 64'd0, 1'b1, 2'b01, 1'b0, 1'b0);
        run(32'hB4000023, 5'd1, 2);

        push_acc("cbz_nt");
        push_ex("cbz_nt.ex", mkcw(5'd0, 5'd3, 5'd31, 5'b01000, 10'b0001000000), 64'd0);
        push("cbz_nt.br", CW_IDLE, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 2'b00, 1'b0, 1'b0);
        run(32'hB4FFFFC3, 5'd0, 2);

        push_acc("cbnz_t");
        push_ex("cbnz_t.ex", mkcw(5'd0, 5'd3, 5'd31, 5'b01000, 10'b0001000000), 64'd0);
        push("cbnz_t.br", CW_IDLE, 64'd12, 1'b1, 2'b01, 1'b0, 1'b0);
        run(32'hB5000083, 5'd0, 2);

        push_acc("b");
        push("b.ex", CW_IDLE, 64'd4, 1'b1, 2'b01, 1'b0, 1'b0);
        run(32'h14000002, 5'd0, 1);

`ifdef BCOND_EN
        push_acc("beq_t");
        push_ex("beq_t.ex", CW_IDLE, 64'd0);
        push("beq_t.br", CW_IDLE, 64'd0, 1'b1, 2'b01, 1'b0, 1'b0);
        run(32'h54000020, 5'b00010, 2);

        push_acc("bgt_nt");
        push_ex("bgt_nt.ex", CW_IDLE, 64'd0);
        push("bgt_nt.br", CW_IDLE, 64'd4, 1'b0, 2'b00, 1'b0, 1'b0);
        run(32'h5400004C, 5'b00010, 2);
`else
        push_acc("bcond_ill");
        push_ex("bcond_ill.ex", CW_IDLE, 64'd0);
        push("bcond_ill.halt", CW_IDLE, 64'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        run(32'h54000020, 5'd0, 2);
        #1 rst = 1'b1;
        reset_checks("bcond_rst");
        @(posedge clk); #1 rst = 1'b0;
`endif

        push_acc("illegal");
        push_ex("illegal.ex", CW_IDLE, 64'd0);
        for (int i = 0; i < 3; i++)
            push("illegal.halt", CW_IDLE, 64'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        run(32'h00000000, 5'd0, 4);
        #1 rst = 1'b1;
        reset_checks("halt_rst");
        @(posedge clk); #1 rst = 1'b0;

        // Abort an LDUR while it is in MEM
        push_acc("ldur_ab");
        push_ex("ldur_ab.ex", mkcw(5'd0, 5'd1, 5'd0, 5'b01000, 10'b0101010100), 64'hFFFF_FFFF_FFFF_FFF8);
        run(32'hF85F8022, 5'd0, 1);
        #1 rst = 1'b1;
        reset_checks("mem_rst");
        chk("mem_rst.reg_w", {63'd0, cw[9]}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        push_acc("add");
        push_ex("add", mkcw(5'd7, 5'd2, 5'd3, 5'b01000, 10'b1001000000), 64'd0);
        run(32'h8B030047, 5'd0, 1);

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
